// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports (port 1 has priority),
// NUM_RD combinational read ports with write-through bypass, a per-entry pending
// (scoreboard) bit, and a sequencer that clears the whole file one entry per cycle.
// Entry 0 is hard-wired to zero and is never pending.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,

    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,

    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_pend,

    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,

    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_CLR = ADDR_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t          state;
    logic [ADDR_W-1:0]   clr_cnt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    pending;

    logic                wr0_eff;
    logic                wr1_eff;
    logic                mark_eff;

    // Writes and marks are qualified once here: address 0 is read-only and the
    // clear sequencer owns the array while it runs.
    assign wr0_eff  = we0     && (waddr0    != '0) && !clr_busy;
    assign wr1_eff  = we1     && (waddr1    != '0) && !clr_busy;
    assign mark_eff = mark_en && (mark_addr != '0) && !clr_busy;

    // Clear sequencer: walks entries 1..DEPTH-1, one per cycle, then returns to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_cnt  <= FIRST_CLR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_req is deliberately not looked at here: a running clear
                    // cannot be restarted or extended.
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt  <= clr_cnt + FIRST_CLR;
                    end
                end
                default: begin
                    state    <= IDLE;
                    clr_cnt  <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: clear sequencer first, then write port 1 over write port 0.
    // NOTE: the array is reset on purpose -- reset must leave every entry reading 0,
    // so it cannot be mapped to a reset-less RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            mem[0] <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                if (clr_busy && (clr_cnt == ADDR_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr1_eff && (waddr1 == ADDR_W'(i))) begin
                    mem[i] <= wdata1;
                end else if (wr0_eff && (waddr0 == ADDR_W'(i))) begin
                    mem[i] <= wdata0;
                end
            end
        end
    end

    // Scoreboard bits: a mark beats a same-cycle write to the same entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending[0] <= 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                if (clr_busy && (clr_cnt == ADDR_W'(i))) begin
                    pending[i] <= 1'b0;
                end else if (mark_eff && (mark_addr == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if ((wr1_eff && (waddr1 == ADDR_W'(i))) ||
                             (wr0_eff && (waddr0 == ADDR_W'(i)))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // One combinational read path per port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rp;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // Read data with write-through bypass; the qualified enables already
        // disable the bypass for address 0 and while clearing.
        // NOTE: each output gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            rd = mem[ra];
            if (wr1_eff && (waddr1 == ra)) begin
                rd = wdata1;
            end else if (wr0_eff && (waddr0 == ra)) begin
                rd = wdata0;
            end
        end

        // Pending bit with this cycle's mark/write already applied.
        always_comb begin
            rp = pending[ra];
            if (mark_eff && (mark_addr == ra)) begin
                rp = 1'b1;
            end else if ((wr1_eff && (waddr1 == ra)) || (wr0_eff && (waddr0 == ra))) begin
                rp = 1'b0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
        assign rd_pend[k]                = rp;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (32-bit, 32 entries, 2 read ports) and a
// small instance (16-bit, 8 entries, 4 read ports) share one stimulus stream. A
// behavioural model (arrays plus a "entries left to clear" count) predicts every
// read port, pending bit and busy flag of both instances each cycle.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        we0, we1, mark_en, clr_req;
    logic [4:0]  waddr0, waddr1, mark_addr;
    logic [31:0] wdata0, wdata1;
    logic [4:0]  ra0, ra1, ra2, ra3;

    logic [63:0] rdata_a;
    logic [1:0]  pend_a;
    logic        busy_a;
    logic [63:0] rdata_b;
    logic [3:0]  pend_b;
    logic        busy_b;

    regfile_mp dut_a (
        .clk       (clk),
        .reset     (reset),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .raddr     ({ra1, ra0}),
        .rdata     (rdata_a),
        .rd_pend   (pend_a),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .clr_req   (clr_req),
        .clr_busy  (busy_a)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .we0       (we0),
        .waddr0    (waddr0[2:0]),
        .wdata0    (wdata0[15:0]),
        .we1       (we1),
        .waddr1    (waddr1[2:0]),
        .wdata1    (wdata1[15:0]),
        .raddr     ({ra3[2:0], ra2[2:0], ra1[2:0], ra0[2:0]}),
        .rdata     (rdata_b),
        .rd_pend   (pend_b),
        .mark_en   (mark_en),
        .mark_addr (mark_addr[2:0]),
        .clr_req   (clr_req),
        .clr_busy  (busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem  [2][32];
    logic        m_pend [2][32];
    int          m_left [2];

    function automatic int dep(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] dmask(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [4:0] ra_sel(input int k);
        case (k)
            0:       return ra0;
            1:       return ra1;
            2:       return ra2;
            default: return ra3;
        endcase
    endfunction

    function automatic logic [31:0] exp_rdata(input int i, input logic [4:0] a_in);
        int d  = dep(i);
        int a  = int'(a_in) % d;
        int w0 = int'(waddr0) % d;
        int w1 = int'(waddr1) % d;
        bit busy = (m_left[i] > 0);
        if (!busy && we1 && w1 != 0 && w1 == a) return wdata1 & dmask(i);
        if (!busy && we0 && w0 != 0 && w0 == a) return wdata0 & dmask(i);
        return m_mem[i][a];
    endfunction

    function automatic logic exp_pend(input int i, input logic [4:0] a_in);
        int d  = dep(i);
        int a  = int'(a_in) % d;
        int w0 = int'(waddr0) % d;
        int w1 = int'(waddr1) % d;
        int ma = int'(mark_addr) % d;
        bit busy = (m_left[i] > 0);
        if (!busy && mark_en && ma != 0 && ma == a) return 1'b1;
        if (!busy && ((we1 && w1 != 0 && w1 == a) || (we0 && w0 != 0 && w0 == a))) return 1'b0;
        return m_pend[i][a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0;
            for (int j = 0; j < 32; j++) begin
                m_mem[i][j]  = '0;
                m_pend[i][j] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int d  = dep(i);
            int w0 = int'(waddr0) % d;
            int w1 = int'(waddr1) % d;
            int ma = int'(mark_addr) % d;
            if (m_left[i] > 0) begin
                int e = d - m_left[i];
                m_mem[i][e]  = '0;
                m_pend[i][e] = 1'b0;
                m_left[i]--;
            end else begin
                if (we0 && w0 != 0) begin m_mem[i][w0] = wdata0 & dmask(i); m_pend[i][w0] = 1'b0; end
                if (we1 && w1 != 0) begin m_mem[i][w1] = wdata1 & dmask(i); m_pend[i][w1] = 1'b0; end
                if (mark_en && ma != 0) m_pend[i][ma] = 1'b1;
                if (clr_req) m_left[i] = d - 1;
            end
        end
    endtask

    // ---------------- cycle driver ----------------
    logic last_busy_a, last_busy_b;

    // Called at a falling edge with inputs already driven: compare everything
    // against the model, then advance model and DUT through one rising edge.
    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("A rdata%0d", k), 64'(rdata_a[k*32 +: 32]), 64'(exp_rdata(0, ra_sel(k))));
            check($sformatf("A rd_pend%0d", k), 64'(pend_a[k]), 64'(exp_pend(0, ra_sel(k))));
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("B rdata%0d", k), 64'(rdata_b[k*16 +: 16]), 64'(exp_rdata(1, ra_sel(k))));
            check($sformatf("B rd_pend%0d", k), 64'(pend_b[k]), 64'(exp_pend(1, ra_sel(k))));
        end
        check("A clr_busy", 64'(busy_a), 64'(m_left[0] > 0));
        check("B clr_busy", 64'(busy_b), 64'(m_left[1] > 0));
        last_busy_a = busy_a;
        last_busy_b = busy_b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we0 = 0; we1 = 0; mark_en = 0; clr_req = 0;
        waddr0 = 0; waddr1 = 0; mark_addr = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom % 32);
    endfunction

    // ---------------- directed vectors (instance A, constants) ----------------
    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        mk;
        logic [4:0]  ma;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_p0;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cnt_a, cnt_b;

        vecs[0] = '{1'b1, 5'd5, 32'h11,       1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 5'd5, 5'd5, 32'h22, 32'h22, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'h22, 32'h22, 1'b0};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  1'b0};
        vecs[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 5'd7, 5'd5, 32'h0,  32'h22, 1'b1};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'h0,  32'h0,  1'b1};
        vecs[6] = '{1'b1, 5'd7, 32'hA5,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'hA5, 32'hA5, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'hA5, 32'hA5, 1'b0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h3C, 1'b1, 5'd7, 5'd7, 5'd7, 32'h3C, 32'h3C, 1'b1};
        vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd7, 32'h3C, 32'h3C, 1'b1};

        // Reset state: everything reads zero, nothing busy.
        reset = 1'b1;
        idle_inputs();
        ra0 = 0; ra1 = 0; ra2 = 0; ra3 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset busy A", 64'(busy_a), 64'd0);
        check("reset busy B", 64'(busy_b), 64'd0);
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a);
            #1;
            check("reset rdata A", 64'(rdata_a[31:0]), 64'd0);
            check("reset pend A", 64'(pend_a[0]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors: dual write, address-0 bypass, scoreboard.
        for (int v = 0; v < 10; v++) begin
            we0 = vecs[v].we0; waddr0 = vecs[v].wa0; wdata0 = vecs[v].wd0;
            we1 = vecs[v].we1; waddr1 = vecs[v].wa1; wdata1 = vecs[v].wd1;
            mark_en = vecs[v].mk; mark_addr = vecs[v].ma;
            ra0 = vecs[v].r0; ra1 = vecs[v].r1; ra2 = vecs[v].r0; ra3 = vecs[v].r1;
            #1;
            check($sformatf("vec%0d rdata0", v), 64'(rdata_a[31:0]),  64'(vecs[v].e_rd0));
            check($sformatf("vec%0d rdata1", v), 64'(rdata_a[63:32]), 64'(vecs[v].e_rd1));
            check($sformatf("vec%0d rd_pend0", v), 64'(pend_a[0]),    64'(vecs[v].e_p0));
            step();
        end
        idle_inputs();

        // Clear sequence: fill, clear, try writes/marks/requests while busy.
        for (int a = 1; a < 32; a++) begin
            we0 = 1; waddr0 = 5'(a); wdata0 = {8'hC0, 8'(a), 8'h5A, 8'(a)};
            ra0 = 5'(a); ra1 = 5'(31 - a); ra2 = 5'(a); ra3 = 5'(a + 1);
            step();
        end
        idle_inputs();
        clr_req = 1;
        step();
        clr_req = 0;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_left[0] > 0) begin
                we0 = 1'($urandom); waddr0 = 5'($urandom); wdata0 = $urandom | 32'h1;
                we1 = 1'($urandom); waddr1 = 5'($urandom); wdata1 = $urandom | 32'h1;
                mark_en = 1'($urandom); mark_addr = 5'($urandom);
                clr_req = (c == 2 || c == 3);
            end else begin
                idle_inputs();
            end
            ra0 = 5'($urandom); ra1 = 5'($urandom); ra2 = 5'($urandom); ra3 = 5'($urandom);
            step();
            if (last_busy_a) cnt_a++;
            if (last_busy_b) cnt_b++;
        end
        check("clear cycles A", 64'(cnt_a), 64'd31);
        check("clear cycles B", 64'(cnt_b), 64'd7);
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a); ra1 = 5'(a);
            #1;
            check("after clear rdata A", 64'(rdata_a[31:0]), 64'd0);
            check("after clear pend A", 64'(pend_a[0]), 64'd0);
            step();
        end

        // Reset in the middle of a clear.
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h77; step();
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h99; step();
        idle_inputs();
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        check("mid-clear reset busy A", 64'(busy_a), 64'd0);
        check("mid-clear reset busy B", 64'(busy_b), 64'd0);
        for (int a = 0; a < 32; a++) begin
            ra0 = 5'(a); ra1 = 5'(31 - a);
            #1;
            check("mid-clear reset rdata0", 64'(rdata_a[31:0]), 64'd0);
            check("mid-clear reset rdata1", 64'(rdata_a[63:32]), 64'd0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h5;
        step();
        idle_inputs();
        ra0 = 5'd3;
        #1;
        check("post-reset write", 64'(rdata_a[31:0]), 64'h5);
        step();

        // Randomised traffic against the model.
        for (int c = 0; c < 800; c++) begin
            we0 = 1'($urandom); waddr0 = rnd_addr(); wdata0 = $urandom;
            we1 = 1'($urandom); waddr1 = rnd_addr(); wdata1 = $urandom;
            mark_en = ($urandom % 3 == 0); mark_addr = rnd_addr();
            clr_req = ($urandom % 60 == 0);
            ra0 = rnd_addr(); ra1 = rnd_addr(); ra2 = rnd_addr(); ra3 = rnd_addr();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
